// File: rtl/wave_meter_pkg.sv
// wave_meter_pkg: shared types and defaults for the period meter.
// Holds the FSM state type and default parameter values.
package wave_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } meter_state_t;

  localparam int DEF_CNT_W       = 12;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 4000;

endpackage

// File: rtl/edge_sync.sv
// edge_sync: synchronizes wave_in and detects its edges.
// Ports: clk, reset (async low), wave_in -> wave_s, rise, fall.
module edge_sync
  import wave_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic wave_in,
  output logic wave_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   wave_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain  <= '0;
      wave_d <= 1'b0;
    end else begin
      chain  <= {chain[SYNC_STAGES-2:0], wave_in};
      wave_d <= chain[SYNC_STAGES-1];
    end
  end

  assign wave_s = chain[SYNC_STAGES-1];
  assign rise   = wave_s & ~wave_d;
  assign fall   = ~wave_s & wave_d;

endmodule

// File: rtl/wave_period_meter.sv
// wave_period_meter: measures high, low and period of a square wave.
// Ports: clk, reset (async low), wave_in -> high_cnt, low_cnt,
//        period_cnt, meas_valid (1-cycle pulse), stuck (level).
module wave_period_meter
  import wave_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wave_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period_cnt,
  output logic             meas_valid,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             wave_s_unused;
  logic             rise;
  logic             fall;
  logic             any_edge;
  logic             hit;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_nxt;
  logic [CNT_W-1:0] hi_lat;
  logic             lat_hi;
  logic             fire;
  meter_state_t     state;
  meter_state_t     state_nxt;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .wave_in(wave_in),
    .wave_s (wave_s_unused),
    .rise   (rise),
    .fall   (fall)
  );

  assign any_edge = rise | fall;

  // acc is the length so far of the current level; it saturates.
  always_comb begin
    acc_nxt = acc + ONE;
    if (any_edge) begin
      acc_nxt = ONE;
    end else if (acc == TMO) begin
      acc_nxt = acc;
    end
  end

  // An edge always beats a timeout in the same cycle.
  assign hit = !any_edge && (acc_nxt == TMO);

  always_comb begin
    state_nxt = state;
    lat_hi    = 1'b0;
    fire      = 1'b0;
    unique case (1'b1)
      hit: begin
        state_nxt = IDLE;
      end
      rise: begin
        fire      = (state == LOW);
        state_nxt = HIGH;
      end
      fall: begin
        if (state == HIGH) begin
          lat_hi    = 1'b1;
          state_nxt = LOW;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      stuck <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      if (hit) begin
        stuck <= 1'b1;
      end else if (any_edge) begin
        stuck <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_lat     <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= fire;
      if (lat_hi) begin
        hi_lat <= acc;
      end
      if (fire) begin
        high_cnt   <= hi_lat;
        low_cnt    <= acc;
        period_cnt <= {1'b0, hi_lat} + {1'b0, acc};
      end
    end
  end

endmodule
